// File: rtl/keypad_scanner.sv
// 4x8 key matrix scanner: one row strobe at a time, a two-flop column synchroniser,
// and an independent debounce counter for each of the 32 keys.

module keypad_key #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic Clk,
    input  logic nReset,
    input  logic en,
    input  logic sample,
    output logic deb,
    output logic flip
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW:0] LAST = DEBOUNCE_SCANS[CW:0];

    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign flip    = en && (sample != deb) && (cnt_inc == LAST);

    // Any sample that agrees with the committed level restarts the run.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (en) begin
            if (sample == deb) begin
                cnt <= '0;
            end else if (flip) begin
                deb <= sample;
                cnt <= '0;
            end else begin
                cnt <= cnt_inc[CW-1:0];
            end
        end
    end
endmodule

module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 8000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       Clk,
    input  logic       nReset,
    output logic [3:0] row_drive,
    input  logic [7:0] col_sense,
    output logic [7:0] key_row1,
    output logic [7:0] key_row2,
    output logic [7:0] key_row3,
    output logic [7:0] key_row4,
    output logic       key_change
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SETTLE_CYCLES - 1);

    logic [SW-1:0]   slot_cnt;
    logic [7:0]      sync1, sync2;
    logic            tc;
    logic [3:0][7:0] deb;
    logic [3:0][7:0] flip;

    assign tc = (slot_cnt == SLOT_LAST);

    // Only the row currently strobed low is sampled, so one row word moves per edge.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            keypad_key #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_key (
                .Clk    (Clk),
                .nReset (nReset),
                .en     (tc & ~row_drive[r]),
                .sample (~sync2[c]),
                .deb    (deb[r][c]),
                .flip   (flip[r][c])
            );
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync1      <= 8'hFF;
            sync2      <= 8'hFF;
            slot_cnt   <= '0;
            row_drive  <= 4'b1110;
            key_change <= 1'b0;
        end else begin
            sync1      <= col_sense;
            sync2      <= sync1;
            key_change <= |flip;
            if (tc) begin
                slot_cnt  <= '0;
                row_drive <= {row_drive[2:0], row_drive[3]};
            end else begin
                slot_cnt  <= slot_cnt + 1'b1;
            end
        end
    end

    assign key_row1 = deb[0];
    assign key_row2 = deb[1];
    assign key_row3 = deb[2];
    assign key_row4 = deb[3];
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a matrix model drives col_sense, and each
// key_change pulse is matched against the next expected snapshot of the four row words.

module tb_keypad_scanner;
    localparam int SC = 4;
    localparam int DS = 3;

    typedef struct {
        logic [7:0] r1, r2, r3, r4;
    } snap_t;

    logic            Clk = 1'b0;
    logic            nReset = 1'b0;
    logic [3:0]      row_drive;
    logic [7:0]      col_sense;
    logic [7:0]      key_row1, key_row2, key_row3, key_row4;
    logic            key_change;
    logic [3:0][7:0] pressed = '0;

    snap_t sb[$];
    snap_t exp_snap;
    int    nchk = 0, npass = 0, npulse = 0;

    always #5 Clk = ~Clk;

    keypad_scanner #(.SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .row_drive  (row_drive),
        .col_sense  (col_sense),
        .key_row1   (key_row1),
        .key_row2   (key_row2),
        .key_row3   (key_row3),
        .key_row4   (key_row4),
        .key_change (key_change)
    );

    // Matrix: a pressed key pulls its column low while its row is strobed.
    always_comb begin
        col_sense = 8'hFF;
        for (int r = 0; r < 4; r++)
            if (!row_drive[r]) col_sense = col_sense & ~pressed[r];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic snap_t mk(input logic [7:0] r1, r2, r3, r4);
        snap_t s;
        s.r1 = r1; s.r2 = r2; s.r3 = r3; s.r4 = r4;
        return s;
    endfunction

    // Advance to the negedge just after row1 becomes active again.
    task automatic wait_scan();
        int n = 0;
        logic [3:0] prev = row_drive;
        logic done = 1'b0;
        while (!done) begin
            @(negedge Clk);
            n++;
            if (row_drive == 4'b1110 && prev != 4'b1110) done = 1'b1;
            else if (n > 200) begin
                chk("scan_timeout", n, 0);
                done = 1'b1;
            end
            prev = row_drive;
        end
    endtask

    task automatic scans(input int k);
        repeat (k) wait_scan();
    endtask

    always @(negedge Clk) begin
        if (nReset && key_change) begin
            npulse++;
            if (sb.size() == 0) chk("spurious_chg", key_change, 0);
            else begin
                exp_snap = sb.pop_front();
                chk("pulse_r1", key_row1, exp_snap.r1);
                chk("pulse_r2", key_row2, exp_snap.r2);
                chk("pulse_r3", key_row3, exp_snap.r3);
                chk("pulse_r4", key_row4, exp_snap.r4);
            end
        end
    end

    initial begin
        logic [3:0] exp_row;

        // Reset state, then the row strobe sequence.
        repeat (3) @(negedge Clk);
        chk("rst_row", row_drive, 4'b1110);
        chk("rst_keys", {key_row1, key_row2, key_row3, key_row4}, 0);
        chk("rst_chg", key_change, 0);
        nReset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge Clk);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk("row_seq", row_drive, exp_row);
        end

        // Short press: two samples only, never committed.
        wait_scan();
        pressed[1][2] = 1'b1;
        scans(2);
        pressed[1][2] = 1'b0;
        scans(4);
        chk("glitch_r2", key_row2, 0);
        chk("glitch_pulses", npulse, 0);

        // Held key commits on the third row2 sample.
        sb.push_back(mk(8'h00, 8'h04, 8'h00, 8'h00));
        pressed[1][2] = 1'b1;
        scans(4);
        chk("hold_r2", key_row2, 8'h04);
        chk("hold_other", {key_row1, key_row3, key_row4}, 0);
        chk("hold_pulses", npulse, 1);

        // Release.
        sb.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00));
        pressed[1][2] = 1'b0;
        scans(4);
        chk("rel_r2", key_row2, 0);
        chk("rel_pulses", npulse, 2);

        // Two keys in different rows, each with its own pulse (row1 first).
        sb.push_back(mk(8'h80, 8'h00, 8'h00, 8'h00));
        sb.push_back(mk(8'h80, 8'h00, 8'h00, 8'h01));
        pressed[3][0] = 1'b1;
        pressed[0][7] = 1'b1;
        scans(4);
        chk("two_r1", key_row1, 8'h80);
        chk("two_r4", key_row4, 8'h01);
        chk("two_pulses", npulse, 4);

        // Reset mid-debounce discards the partial count.
        pressed[2][5] = 1'b1;
        scans(2);
        nReset = 1'b0;
        pressed[3][0] = 1'b0;
        pressed[0][7] = 1'b0;
        #1;
        chk("mid_rst_keys", {key_row1, key_row2, key_row3, key_row4}, 0);
        chk("mid_rst_row", row_drive, 4'b1110);
        chk("mid_rst_chg", key_change, 0);
        @(negedge Clk);
        nReset = 1'b1;
        sb.push_back(mk(8'h00, 8'h00, 8'h20, 8'h00));
        scans(2);
        chk("rst_partial_r3", key_row3, 0);
        scans(2);
        chk("rst_fresh_r3", key_row3, 8'h20);
        chk("final_pulses", npulse, 5);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
